hub75_bcm_scanner: RTL and testbench



---
 rtl/hub75_bcm_scanner.sv | 177 +++++++++++++++++
 tb/tb_hub75_bcm_scanner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_bcm_scanner.sv
// rtl/hub75_bcm_scanner.sv - HUB75 row-pair BCM scanner: shift, latch, weighted OE per bit plane.
// Optional HUB75_ANTIGHOST_EN inserts a dark BLANK gap after every SHOW.
module hub75_bcm_scanner #(
    parameter int NUM_COLS     = 64,
    parameter int SCAN_RATE    = 32,
    parameter int RGB_RES      = 9,
    parameter int BASE_ON      = 8,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic [1:0][NUM_COLS-1:0][RGB_RES-1:0] column_data,
    input  logic [$clog2(SCAN_RATE)-1:0]          row_addr,
    input  logic                                  tvalid,
    output logic                                  tready,
    output logic [2:0]                            rgb0,
    output logic [2:0]                            rgb1,
    output logic                                  led_clk,
    output logic                                  led_latch,
    output logic                                  led_output_enable,
    output logic [$clog2(SCAN_RATE)-1:0]          led_addr
);
    localparam int COLOR_BITS = RGB_RES / 3;
    localparam int AW = $clog2(SCAN_RATE);
    localparam int CW = $clog2(NUM_COLS);
    localparam int PW = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
    localparam int OW = $clog2((BASE_ON << (COLOR_BITS - 1)) + 1);
    localparam int BW = $clog2(BLANK_CYCLES + 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(NUM_COLS - 1);
    localparam logic [PW-1:0] PLANE_LAST = PW'(COLOR_BITS - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, LATCH, SHOW, BLANK} state_t;

    state_t                                state, state_nxt;
    logic [1:0][NUM_COLS-1:0][RGB_RES-1:0] snap, snap_nxt;
    logic [AW-1:0]                         snap_addr, snap_addr_nxt;
    logic [CW-1:0]                         col, col_nxt;
    logic                                  phase, phase_nxt;
    logic [PW-1:0]                         plane, plane_nxt;
    logic [OW-1:0]                         on_cnt, on_nxt, on_last;
    logic [BW-1:0]                         blank_cnt, blank_nxt;
    logic                                  plane_done;
    logic                                  tready_nxt, led_clk_nxt, latch_nxt, oe_nxt;
    logic [2:0]                            rgb0_nxt, rgb1_nxt;
    logic [AW-1:0]                         addr_nxt;

    // {R,G,B} bits of one pixel for bit plane p
    function automatic logic [2:0] plane_bits(input logic [RGB_RES-1:0] px, input logic [PW-1:0] p);
        plane_bits = {px[2*COLOR_BITS + int'(p)], px[COLOR_BITS + int'(p)], px[int'(p)]};
    endfunction

    assign on_last = OW'((BASE_ON << plane) - 1);

    always_comb begin
        state_nxt     = state;
        snap_nxt      = snap;
        snap_addr_nxt = snap_addr;
        col_nxt       = col;
        phase_nxt     = phase;
        plane_nxt     = plane;
        on_nxt        = on_cnt;
        blank_nxt     = blank_cnt;
        plane_done    = 1'b0;
        tready_nxt    = 1'b0;
        led_clk_nxt   = 1'b0;
        latch_nxt     = 1'b0;
        oe_nxt        = 1'b1;
        rgb0_nxt      = rgb0;
        rgb1_nxt      = rgb1;
        addr_nxt      = led_addr;
        case (state)
            IDLE: begin
                if (tvalid && tready) begin
                    snap_nxt      = column_data;
                    snap_addr_nxt = row_addr;
                    state_nxt     = SHIFT;
                    plane_nxt     = '0;
                    col_nxt       = '0;
                    phase_nxt     = 1'b0;
                end else begin
                    tready_nxt = 1'b1;
                end
            end
            SHIFT: begin
                if (!phase) begin
                    phase_nxt   = 1'b1;
                    led_clk_nxt = 1'b1;
                end else if (col == COL_LAST) begin
                    state_nxt = LATCH;
                    latch_nxt = 1'b1;
                    addr_nxt  = snap_addr;
                end else begin
                    col_nxt   = col + 1'b1;
                    phase_nxt = 1'b0;
                end
            end
            LATCH: begin
                state_nxt = SHOW;
                on_nxt    = '0;
                oe_nxt    = 1'b0;
            end
            SHOW: begin
                if (on_cnt == on_last) begin
`ifdef HUB75_ANTIGHOST_EN
                    state_nxt = BLANK;
                    blank_nxt = '0;
`else
                    plane_done = 1'b1;
`endif
                end else begin
                    on_nxt = on_cnt + 1'b1;
                    oe_nxt = 1'b0;
                end
            end
            BLANK: begin
                if (blank_cnt == BLANK_LAST) plane_done = 1'b1;
                else                         blank_nxt = blank_cnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        if (plane_done) begin
            if (plane == PLANE_LAST) begin
                state_nxt  = IDLE;
                tready_nxt = 1'b1;
            end else begin
                state_nxt = SHIFT;
                plane_nxt = plane + 1'b1;
                col_nxt   = '0;
                phase_nxt = 1'b0;
            end
        end

        // Outputs are registered, so present the pixel of the column being entered
        if (state_nxt == SHIFT && !phase_nxt) begin
            rgb0_nxt = plane_bits(snap_nxt[0][col_nxt], plane_nxt);
            rgb1_nxt = plane_bits(snap_nxt[1][col_nxt], plane_nxt);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state             <= IDLE;
            snap              <= '0;
            snap_addr         <= '0;
            col               <= '0;
            phase             <= 1'b0;
            plane             <= '0;
            on_cnt            <= '0;
            blank_cnt         <= '0;
            tready            <= 1'b0;
            rgb0              <= '0;
            rgb1              <= '0;
            led_clk           <= 1'b0;
            led_latch         <= 1'b0;
            led_output_enable <= 1'b1;
            led_addr          <= '0;
        end else begin
            state             <= state_nxt;
            snap              <= snap_nxt;
            snap_addr         <= snap_addr_nxt;
            col               <= col_nxt;
            phase             <= phase_nxt;
            plane             <= plane_nxt;
            on_cnt            <= on_nxt;
            blank_cnt         <= blank_nxt;
            tready            <= tready_nxt;
            rgb0              <= rgb0_nxt;
            rgb1              <= rgb1_nxt;
            led_clk           <= led_clk_nxt;
            led_latch         <= latch_nxt;
            led_output_enable <= oe_nxt;
            led_addr          <= addr_nxt;
        end
    end
endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// tb/tb_hub75_bcm_scanner.sv - directed table-driven bench for hub75_bcm_scanner.
module tb_hub75_bcm_scanner;
`ifdef HUB75_ANTIGHOST_EN
    localparam int SNAP_CYC = 455;
`else
    localparam int SNAP_CYC = 443;
`endif

    logic                    clk_in = 1'b0;
    logic                    rst_in = 1'b0;
    logic [1:0][63:0][8:0]   column_data = '0;
    logic [4:0]              row_addr = '0;
    logic                    tvalid = 1'b0;
    logic                    tready;
    logic [2:0]              rgb0, rgb1;
    logic                    led_clk, led_latch, led_output_enable;
    logic [4:0]              led_addr;

    int tests = 0;
    int failed = 0;
    logic [2:0] exp0 [3][64];
    logic [2:0] exp1 [3][64];

    typedef struct packed {
        logic [8:0]      up;
        logic [8:0]      lo;
        logic [4:0]      addr;
        logic [2:0][2:0] e0;
        logic [2:0][2:0] e1;
    } vec_t;

    hub75_bcm_scanner dut (
        .clk_in(clk_in), .rst_in(rst_in), .column_data(column_data), .row_addr(row_addr),
        .tvalid(tvalid), .tready(tready), .rgb0(rgb0), .rgb1(rgb1), .led_clk(led_clk),
        .led_latch(led_latch), .led_output_enable(led_output_enable), .led_addr(led_addr)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic fill(input logic [8:0] u, input logic [8:0] l);
        for (int k = 0; k < 64; k++) begin
            column_data[0][k] = u;
            column_data[1][k] = l;
        end
    endtask

    task automatic set_exp(input logic [2:0][2:0] e0, input logic [2:0][2:0] e1);
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < 64; k++) begin
                exp0[p][k] = e0[p];
                exp1[p][k] = e1[p];
            end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk_in);
        while (!tready && n < 1000) begin
            @(negedge clk_in);
            n++;
        end
        check("wait_ready", {31'b0, tready}, 1);
    endtask

    // Called at a negedge with tready=1 and tvalid=1; the next posedge is the handshake
    task automatic watch(input string tag, input int exp_addr, input bit hold,
                         input logic [8:0] nu, input logic [8:0] nl, input logic [4:0] naddr);
        int cyc = 0, rises = 0, pl_rises = 0, latches = 0, rgb_err = 0, latch_err = 0;
        int run = 0, nruns = 0, addr_seen = -1;
        int runs [3] = '{0, 0, 0};
        logic prev_clk = 1'b0;
        bit done = 0;
        @(posedge clk_in);
        while (!done && cyc <= 2000) begin
            @(negedge clk_in);
            if (cyc == 0) begin
                check({tag, "_capture_tready"}, {31'b0, tready}, 0);
                if (!hold) tvalid = 1'b0;
            end
            if (hold && cyc == 10) begin
                fill(nu, nl);
                row_addr = naddr;
            end
            if (led_clk && !prev_clk) begin
                if (latches < 3 && pl_rises < 64) begin
                    if (rgb0 !== exp0[latches][pl_rises] || rgb1 !== exp1[latches][pl_rises]) rgb_err++;
                end else rgb_err++;
                rises++;
                pl_rises++;
            end
            prev_clk = led_clk;
            if (led_latch) begin
                if (!led_output_enable || led_clk) latch_err++;
                if (latches == 0) addr_seen = int'(led_addr);
                latches++;
                pl_rises = 0;
            end
            if (!led_output_enable) run++;
            else if (run > 0) begin
                if (nruns < 3) runs[nruns] = run;
                nruns++;
                run = 0;
            end
            if (cyc > 0 && tready) done = 1;
            else begin
                @(posedge clk_in);
                cyc++;
            end
        end
        check({tag, "_clk_rises"}, rises, 192);
        check({tag, "_rgb_errors"}, rgb_err, 0);
        check({tag, "_latches"}, latches, 3);
        check({tag, "_latch_qual"}, latch_err, 0);
        check({tag, "_addr"}, addr_seen, exp_addr);
        check({tag, "_oe_runs"}, nruns, 3);
        check({tag, "_oe_run0"}, runs[0], 8);
        check({tag, "_oe_run1"}, runs[1], 16);
        check({tag, "_oe_run2"}, runs[2], 32);
        check({tag, "_snap_cycles"}, done ? cyc : -1, SNAP_CYC);
    endtask

    vec_t vecs [4];

    initial begin
        vecs[0] = '{up: 9'h1FF, lo: 9'h1FF, addr: 5'd5,
                    e0: {3'b111, 3'b111, 3'b111}, e1: {3'b111, 3'b111, 3'b111}};
        vecs[1] = '{up: 9'b100_010_001, lo: 9'd0, addr: 5'd3,
                    e0: {3'b100, 3'b010, 3'b001}, e1: {3'b000, 3'b000, 3'b000}};
        vecs[2] = '{up: 9'b011_101_110, lo: 9'b000_111_000, addr: 5'd31,
                    e0: {3'b011, 3'b101, 3'b110}, e1: {3'b010, 3'b010, 3'b010}};
        vecs[3] = '{up: 9'd0, lo: 9'b001_100_010, addr: 5'd0,
                    e0: {3'b000, 3'b000, 3'b000}, e1: {3'b010, 3'b001, 3'b100}};

        // Reset held 5 cycles
        repeat (5) @(posedge clk_in);
        @(negedge clk_in);
        check("reset_outputs", {tready, rgb0, rgb1, led_clk, led_latch, led_output_enable, led_addr},
              {1'b0, 3'b0, 3'b0, 1'b0, 1'b0, 1'b1, 5'd0});
        rst_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        check("reset_release_tready", {31'b0, tready}, 1);

        for (int v = 0; v < 4; v++) begin
            wait_ready();
            fill(vecs[v].up, vecs[v].lo);
            row_addr = vecs[v].addr;
            set_exp(vecs[v].e0, vecs[v].e1);
            tvalid = 1'b1;
            watch($sformatf("vec%0d", v), int'(vecs[v].addr), 0, 9'd0, 9'd0, 5'd0);
        end

        // Per-column ramp: upper = k, lower = 63-k
        wait_ready();
        for (int k = 0; k < 64; k++) begin
            logic [8:0] u, l;
            u = 9'(k);
            l = 9'(63 - k);
            column_data[0][k] = u;
            column_data[1][k] = l;
            for (int p = 0; p < 3; p++) begin
                exp0[p][k] = {1'b0, u[3+p], u[p]};
                exp1[p][k] = {1'b0, l[3+p], l[p]};
            end
        end
        row_addr = 5'd17;
        tvalid = 1'b1;
        watch("ramp", 17, 0, 9'd0, 9'd0, 5'd0);

        // tvalid held high; data changes mid-display must not be captured until next handshake
        wait_ready();
        fill(9'h1FF, 9'h1FF);
        row_addr = 5'd5;
        set_exp(vecs[0].e0, vecs[0].e1);
        tvalid = 1'b1;
        watch("hold_a", 5, 1, 9'b100_010_001, 9'd0, 5'd9);
        set_exp(vecs[1].e0, vecs[1].e1);
        watch("hold_b", 9, 0, 9'd0, 9'd0, 5'd0);

        // Reset during plane-1 SHOW
        wait_ready();
        fill(9'h1FF, 9'h1FF);
        row_addr = 5'd5;
        tvalid = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        tvalid = 1'b0;
        begin
            int lat = 0, n = 0;
            while (lat < 2 && n < 1000) begin
                @(negedge clk_in);
                if (led_latch) lat++;
                n++;
            end
            check("mid_reach_latch2", lat, 2);
        end
        repeat (5) @(negedge clk_in);
        check("mid_in_show", {31'b0, led_output_enable}, 0);
        rst_in = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        check("mid_reset_outputs", {tready, led_output_enable, led_latch, led_clk, led_addr},
              {1'b0, 1'b1, 1'b0, 1'b0, 5'd0});
        rst_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        check("mid_release_tready", {31'b0, tready}, 1);
        begin
            int act = 0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk_in);
                if (led_clk || led_latch || !led_output_enable || !tready) act++;
            end
            check("mid_no_resume", act, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
